// File: rtl/tdr_scan_driver_if.sv
`default_nettype none
// ============================================================================
// Module      : tdr_scan_driver_if
// Description : Signal bundle between the test-control logic, the scan
//               driver and the boundary-scan wrapper chain.
// Revision    : 1.0 - initial release
// ============================================================================
interface tdr_scan_driver_if #(
   parameter int CHAIN_LEN = 6
);
   // request side
   logic                 start;
   logic [CHAIN_LEN-1:0] wr_data;
   logic [1:0]           tdr_en;
   // serial return from the last wrapper cell
   logic                 CTO;
   // wrapper-facing controls
   logic                 CTI;
   logic                 TDR_CAPTURE;
   logic                 TDR_SHIFT;
   logic                 TDR_UPDATE;
   logic                 INSCANWRAP_TDR_EN;
   logic                 OUTSCANWRAP_TDR_EN;
   // status / result
   logic                 busy;
   logic                 done;
   logic [CHAIN_LEN-1:0] rd_data;

   // test-control logic and chain side
   modport master (
      output start, wr_data, tdr_en, CTO,
      input  CTI, TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE,
             INSCANWRAP_TDR_EN, OUTSCANWRAP_TDR_EN, busy, done, rd_data
   );

   // scan driver side
   modport slave (
      input  start, wr_data, tdr_en, CTO,
      output CTI, TDR_CAPTURE, TDR_SHIFT, TDR_UPDATE,
             INSCANWRAP_TDR_EN, OUTSCANWRAP_TDR_EN, busy, done, rd_data
   );
endinterface
`default_nettype wire

// File: rtl/tdr_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tdr_scan_driver
// Description : Serial initiator for the boundary-scan wrapper chain. One
//               start request runs a full CAPTURE / SHIFT / UPDATE sequence,
//               shifting a parallel word out on CTI while collecting CTO.
// Revision    : 1.0 - initial release
// ============================================================================
module tdr_scan_driver #(
   parameter int CHAIN_LEN = 6
) (
   input  wire logic         TDR_TCK,
   input  wire logic         TDR_RESET,
   tdr_scan_driver_if.slave  bus
);

   localparam int                  c_CNT_W    = $clog2(CHAIN_LEN + 1);
   localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0]  c_LAST_CNT = c_CNT_W'(CHAIN_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_SHIFT   = 2'd2,
      S_UPDATE  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_next_state;
   logic [CHAIN_LEN-1:0] r_sout;
   logic [CHAIN_LEN-1:0] r_sin;
   logic [CHAIN_LEN-1:0] w_sin_next;
   logic [c_CNT_W-1:0]   r_cnt;
   logic [CHAIN_LEN-1:0] r_rd_data;
   logic [1:0]           r_en;
   logic                 r_done;

   // State register; reset always lands in IDLE, even mid-transaction.
   always_ff @(posedge TDR_TCK) begin
      if (TDR_RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode: start is only looked at while idle, so requests
   // arriving during a transaction are dropped rather than queued.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (bus.start) w_next_state = S_CAPTURE;
         S_CAPTURE: w_next_state = S_SHIFT;
         S_SHIFT:   if (r_cnt == c_LAST_CNT) w_next_state = S_UPDATE;
         S_UPDATE:  w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // Shift-in next value: the chain return enters at the MSB so that the
   // first bit received (cell 0) ends up in bit 0 after CHAIN_LEN shifts.
   always_comb begin
      w_sin_next                = r_sin >> 1;
      w_sin_next[CHAIN_LEN-1]   = bus.CTO;
   end

   // Datapath: load on accepted start, shift both registers during SHIFT,
   // publish the collected word in UPDATE and flag it one cycle later.
   always_ff @(posedge TDR_TCK) begin
      if (TDR_RESET) begin
         r_sout    <= '0;
         r_sin     <= '0;
         r_cnt     <= '0;
         r_rd_data <= '0;
         r_en      <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == S_UPDATE);
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_sout <= bus.wr_data;
                  r_en   <= bus.tdr_en;
                  r_cnt  <= '0;
               end
            end
            S_SHIFT: begin
               r_sout <= r_sout >> 1;
               r_sin  <= w_sin_next;
               r_cnt  <= r_cnt + c_CNT_ONE;
            end
            S_UPDATE: begin
               r_rd_data <= r_sin;
            end
            default: begin
            end
         endcase
      end
   end

   // Strobes are decoded straight from the state register, so they are
   // mutually exclusive and glitch-free relative to TDR_TCK.
   assign bus.TDR_CAPTURE        = (r_state == S_CAPTURE);
   assign bus.TDR_SHIFT          = (r_state == S_SHIFT);
   assign bus.TDR_UPDATE         = (r_state == S_UPDATE);
   assign bus.CTI                = (r_state == S_SHIFT) & r_sout[0];
   assign bus.busy               = (r_state != S_IDLE);
   assign bus.done               = r_done;
   assign bus.rd_data            = r_rd_data;
   // Enables stay latched after the transaction so the cells keep driving
   // their updated values.
   assign bus.INSCANWRAP_TDR_EN  = r_en[0];
   assign bus.OUTSCANWRAP_TDR_EN = r_en[1];

endmodule
`default_nettype wire

// File: tb/tb_tdr_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdr_scan_driver
// Description : Self-checking bench for tdr_scan_driver. A cycle-indexed
//               timeline of expected outputs plus a done scoreboard, both
//               filled when a start is accepted by the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdr_scan_driver;

   localparam int CL   = 6;
   localparam int NCYC = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tdr_scan_driver_if #(.CHAIN_LEN(CL)) bus ();
   tdr_scan_driver #(.CHAIN_LEN(CL)) dut (.TDR_TCK(clk), .TDR_RESET(rst), .bus(bus));

   tdr_scan_driver_if #(.CHAIN_LEN(1)) bus1 ();
   tdr_scan_driver #(.CHAIN_LEN(1)) dut1 (.TDR_TCK(clk), .TDR_RESET(rst), .bus(bus1));

   int ncmp = 0;
   int nfail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- wrapper chain models ----------------
   logic [CL-1:0] cells = '0, upd = '0, cap_word = '0;
   always @(posedge clk) begin
      if (bus.TDR_CAPTURE)    cells <= cap_word;
      else if (bus.TDR_SHIFT) cells <= {bus.CTI, cells[CL-1:1]};
      if (bus.TDR_UPDATE)     upd <= cells;
   end
   assign bus.CTO = cells[0];

   logic cell1 = 1'b0, upd1 = 1'b0, cap1 = 1'b0;
   always @(posedge clk) begin
      if (bus1.TDR_CAPTURE)    cell1 <= cap1;
      else if (bus1.TDR_SHIFT) cell1 <= bus1.CTI;
      if (bus1.TDR_UPDATE)     upd1 <= cell1;
   end
   assign bus1.CTO = cell1;

   // ---------------- reference model state ----------------
   // ctl bits: {busy, capture, shift, update, cti, done}
   logic [5:0]    exp_ctl [NCYC];
   logic [1:0]    exp_en  [NCYC];
   logic [CL-1:0] exp_rd  [NCYC];

   typedef struct {
      int            done_cyc;
      logic [CL-1:0] rd;
      logic [CL-1:0] chain;
      logic [1:0]    en;
   } exp_t;
   exp_t sb[$];
   exp_t e;
   int   next_free = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      ncmp++;
      if (act !== req) begin
         nfail++;
         $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   // Drive one cycle of stimulus and update the model for it.
   task automatic drive(input bit s, input bit r, input logic [CL-1:0] wd,
                        input logic [1:0] en, input logic [CL-1:0] cp);
      int k;
      k = cyc;
      rst         = r;
      bus.start   = s;
      bus.wr_data = wd;
      bus.tdr_en  = en;
      if (r) begin
         for (int c = k + 1; c < NCYC; c++) begin
            exp_ctl[c] = '0; exp_en[c] = '0; exp_rd[c] = '0;
         end
         for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].done_cyc > k) sb.delete(i);
         next_free = k + 1;
      end else if (s && k >= next_free && k + CL + 3 < NCYC) begin
         cap_word = cp;
         exp_ctl[k + 1] = 6'b110000;
         for (int d = 0; d < CL; d++)
            exp_ctl[k + 2 + d] = {4'b1010, wd[d], 1'b0};
         exp_ctl[k + CL + 2] = 6'b100100;
         exp_ctl[k + CL + 3] = 6'b000001;
         for (int c = k + 1; c < NCYC; c++) exp_en[c] = en;
         for (int c = k + CL + 3; c < NCYC; c++) exp_rd[c] = cp;
         sb.push_back('{done_cyc: k + CL + 3, rd: cp, chain: wd, en: en});
         next_free = k + CL + 3;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 2'b00, '0);
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < NCYC) begin
         chk("ctl", {26'd0, bus.busy, bus.TDR_CAPTURE, bus.TDR_SHIFT,
                     bus.TDR_UPDATE, bus.CTI, bus.done}, {26'd0, exp_ctl[cyc]});
         chk("en_rd", {24'd0, bus.OUTSCANWRAP_TDR_EN, bus.INSCANWRAP_TDR_EN, bus.rd_data},
             {24'd0, exp_en[cyc], exp_rd[cyc]});
         if (bus.done) begin
            if (sb.size() == 0) begin
               ncmp++; nfail++;
               $display("FAIL sb_empty cycle %0d: done with no expected transaction", cyc);
            end else begin
               e = sb.pop_front();
               chk("done_cyc", cyc, e.done_cyc);
               chk("rd_data", {26'd0, bus.rd_data}, {26'd0, e.rd});
               chk("chain_upd", {26'd0, upd}, {26'd0, e.chain});
               chk("enables", {30'd0, bus.OUTSCANWRAP_TDR_EN, bus.INSCANWRAP_TDR_EN},
                   {30'd0, e.en});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [5:0] c1;
      for (int c = 0; c < NCYC; c++) begin
         exp_ctl[c] = '0; exp_en[c] = '0; exp_rd[c] = '0;
      end
      bus1.start = 1'b0; bus1.wr_data = 1'b0; bus1.tdr_en = 2'b00;

      // reset held two cycles with start asserted
      drive(1'b1, 1'b1, 6'h3f, 2'b11, 6'h15);
      drive(1'b1, 1'b1, 6'h3f, 2'b11, 6'h15);
      idle(2);

      // single transaction
      drive(1'b1, 1'b0, 6'b101100, 2'b01, 6'b010011);
      idle(12);

      // back-to-back with start held high
      for (int i = 0; i < 20; i++)
         drive(1'b1, 1'b0, CL'($urandom), 2'($urandom), CL'($urandom));
      idle(12);

      // busy rejection: extra pulses at offsets 3 and 5
      drive(1'b1, 1'b0, 6'b011010, 2'b10, 6'b110001);
      idle(2);
      drive(1'b1, 1'b0, 6'b111111, 2'b11, 6'b000000);
      idle(1);
      drive(1'b1, 1'b0, 6'b000001, 2'b00, 6'b111110);
      idle(10);

      // reset in the third SHIFT cycle
      drive(1'b1, 1'b0, 6'b100101, 2'b11, 6'b011011);
      idle(3);
      drive(1'b0, 1'b1, '0, 2'b00, '0);
      idle(14);

      // single-cell chain
      bus1.wr_data = 1'b1; bus1.tdr_en = 2'b11; cap1 = 1'b0; bus1.start = 1'b1;
      for (int d = 0; d <= 5; d++) begin
         @(negedge clk);
         c1 = {bus1.busy, bus1.TDR_CAPTURE, bus1.TDR_SHIFT, bus1.TDR_UPDATE,
               bus1.CTI, bus1.done};
         case (d)
            1:       chk("cl1_ctl", {26'd0, c1}, 32'b110000);
            2:       chk("cl1_ctl", {26'd0, c1}, 32'b101010);
            3:       chk("cl1_ctl", {26'd0, c1}, 32'b100100);
            4: begin
               chk("cl1_ctl", {26'd0, c1}, 32'b000001);
               chk("cl1_rd", {31'd0, bus1.rd_data}, 32'd0);
               chk("cl1_upd", {31'd0, upd1}, 32'd1);
               chk("cl1_en", {30'd0, bus1.OUTSCANWRAP_TDR_EN, bus1.INSCANWRAP_TDR_EN}, 32'd3);
            end
            default: chk("cl1_ctl", {26'd0, c1}, 32'd0);
         endcase
         @(posedge clk);
         #1;
         bus1.start = 1'b0;
      end

      // randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++)
         drive($urandom_range(0, 9) < 4, $urandom_range(0, 99) == 0,
               CL'($urandom), 2'($urandom), CL'($urandom));
      idle(CL + 6);

      chk("sb_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
`default_nettype wire
